// File: rtl/mul_share_arb_pkg.sv
// Shared types and sizing helpers for the time-shared constant multiplier arbiter.
package mul_share_arb_pkg;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   localparam int DEF_IN_W  = 6;
   localparam int DEF_COEF  = 51;
   localparam int DEF_OUT_W = 12;

   // Bits needed to hold the largest product (2^in_w-1)*coef.
   function automatic int min_out_w(input int in_w, input int coef);
      longint v;
      int     w;
      v = ((longint'(1) << in_w) - 1) * longint'(coef);
      w = 0;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// Request/result bundle between the operand sources, the arbiter and the downstream stage.
interface mul_share_arb_if
   import mul_share_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = 16
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic [OUT_W-1:0]     out_data;
   logic [ID_W-1:0]      out_id;
   logic                 out_ready;
   logic                 busy;
   logic [CNT_W-1:0]     op_cnt;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, busy, op_cnt
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, busy, op_cnt
   );
endinterface

// File: rtl/mul_share_arb_core.sv
// The single shared multiplier: unsigned x * COEF at full product width.
module mul_const_core
   import mul_share_arb_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int COEF  = DEF_COEF
) (
   input  logic [IN_W-1:0]  x_i,
   output logic [OUT_W-1:0] prod_o
);
   assign prod_o = OUT_W'(x_i) * OUT_W'(COEF);
endmodule

// File: rtl/mul_share_arb_pick.sv
// Round-robin picker: first valid index at or after ptr_i, wrapping at NREQ-1.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);
   int k;

   // Scan from the farthest offset down so the nearest valid index wins last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      k       = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = (int'(ptr_i) + i) % NREQ;
         if (valid_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            idx_o      = ID_W'(k);
            any_o      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mul_share_arb.sv
// Time-shares one constant multiplier among NREQ requesters with a registered, tagged result stage.
module mul_share_arb
   import mul_share_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int IN_W  = DEF_IN_W,
   parameter int COEF  = DEF_COEF,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   mul_share_arb_if.slave bus
);
   if (OUT_W < min_out_w(IN_W, COEF)) begin : g_out_w_check
      $error("mul_share_arb: OUT_W too small for (2^IN_W-1)*COEF");
   end
   if (ID_W != $clog2(NREQ)) begin : g_id_w_check
      $error("mul_share_arb: ID_W must equal clog2(NREQ)");
   end

   state_e           state_q, state_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [ID_W-1:0]  out_id_q, out_id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

   logic [NREQ-1:0]  grant;
   logic [ID_W-1:0]  gidx;
   logic             any_valid;
   logic             accept_ok;
   logic             req_fire;
   logic             out_fire;
   logic [IN_W-1:0]  sel_data;
   logic [OUT_W-1:0] prod;

   rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
      .valid_i (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (gidx),
      .any_o   (any_valid)
   );

   assign sel_data = bus.req_data[gidx*IN_W +: IN_W];

   mul_const_core #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF(COEF)) u_mul (
      .x_i    (sel_data),
      .prod_o (prod)
   );

   assign accept_ok     = (state_q == EMPTY) | bus.out_ready;
   assign req_fire      = any_valid & accept_ok & ~rst;
   assign out_fire      = (state_q == FULL) & bus.out_ready;
   assign bus.req_ready = rst ? '0 : (grant & {NREQ{accept_ok}});

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      rr_ptr_d   = rr_ptr_q;
      op_cnt_d   = op_cnt_q;
      if (req_fire) begin
         state_d    = FULL;
         out_data_d = prod;
         out_id_d   = gidx;
         rr_ptr_d   = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end else if (out_fire) begin
         state_d = EMPTY;
      end
      if (out_fire && (op_cnt_q != {CNT_W{1'b1}})) begin
         op_cnt_d = op_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_id_q   <= '0;
         rr_ptr_q   <= '0;
         op_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         rr_ptr_q   <= rr_ptr_d;
         op_cnt_q   <= op_cnt_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.op_cnt    = op_cnt_q;
   assign bus.busy      = bus.out_valid | (|bus.req_valid);
endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed bench for mul_share_arb against a transaction-level reference model.
module tb_mul_share_arb;
   localparam int NREQ = 4;
   localparam int COEF = 51;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_share_arb_if #(.NREQ(4), .ID_W(2), .IN_W(6), .OUT_W(12), .CNT_W(16)) bus ();

   mul_share_arb #(
      .NREQ(4), .ID_W(2), .IN_W(6), .COEF(51), .OUT_W(12), .CNT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: output register contents, pointer and completion count.
   int m_full = 0;
   int m_data = 0;
   int m_id   = 0;
   int m_ptr  = 0;
   int m_cnt  = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int first_valid(input logic [NREQ-1:0] v, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (v[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic int operand(input int k);
      logic [NREQ*6-1:0] d;
      d = bus.req_data;
      return int'(d[k*6 +: 6]);
   endfunction

   task automatic drive(input logic [NREQ-1:0] rv, input int d0, input int d1,
                        input int d2, input int d3, input logic ordy);
      bus.req_valid = rv;
      bus.req_data  = {6'(d3), 6'(d2), 6'(d1), 6'(d0)};
      bus.out_ready = ordy;
   endtask

   // Compare at the falling edge, advance the model, then step past the rising edge.
   task automatic tick();
      int g;
      int accept;
      int exp_rdy;
      @(negedge clk);
      g      = first_valid(bus.req_valid, m_ptr);
      accept = (m_full == 0) || bus.out_ready;
      exp_rdy = (!rst && g >= 0 && accept) ? (1 << g) : 0;
      check_eq("req_ready", int'(bus.req_ready), exp_rdy);
      check_eq("out_valid", int'(bus.out_valid), m_full);
      check_eq("out_data", int'(bus.out_data), m_data);
      check_eq("out_id", int'(bus.out_id), m_id);
      check_eq("op_cnt", int'(bus.op_cnt), m_cnt);
      check_eq("busy", int'(bus.busy), (m_full != 0 || bus.req_valid != 0) ? 1 : 0);
      if (rst) begin
         m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (m_full != 0 && bus.out_ready) begin
            $display("xfer id=%0d data=%0d", m_id, m_data);
            if (m_cnt < 65535) m_cnt++;
            m_full = 0;
         end
         if (g >= 0 && accept) begin
            m_data = operand(g) * COEF;
            m_id   = g;
            m_full = 1;
            m_ptr  = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive('0, 0, 0, 0, 0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tick();
      check_eq("reset_out_valid", int'(bus.out_valid), 0);
      rst = 1'b0;

      // Single request from requester 0.
      drive(4'b0001, 1, 0, 0, 0, 1'b1);
      tick();
      check_eq("single_data", int'(bus.out_data), 51);
      drive('0, 0, 0, 0, 0, 1'b1);
      tick();
      tick();
      check_eq("single_cnt", int'(bus.op_cnt), 1);

      // All valid from a fresh reset: rotation 0..3 with no bubbles.
      rst = 1'b1; tick(); rst = 1'b0;
      drive(4'b1111, 1, 2, 3, 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("rr_id", int'(bus.out_id), i);
         check_eq("rr_data", int'(bus.out_data), 51 * (i + 1));
      end
      drive('0, 0, 0, 0, 0, 1'b1);
      tick();
      check_eq("rr_cnt", int'(bus.op_cnt), 4);

      // Backpressure with requests pending.
      drive(4'b1111, 5, 6, 7, 8, 1'b1);
      tick();
      bus.out_ready = 1'b0;
      repeat (5) tick();
      check_eq("bp_hold_data", int'(bus.out_data), 5 * 51);
      bus.out_ready = 1'b1;
      tick();
      check_eq("bp_release_id", int'(bus.out_id), 1);

      // Max operand on requester 2, then wrap from pointer 3.
      rst = 1'b1; tick(); rst = 1'b0;
      drive(4'b0100, 0, 0, 63, 0, 1'b1);
      tick();
      check_eq("max_data", int'(bus.out_data), 3213);
      check_eq("max_id", int'(bus.out_id), 2);
      drive(4'b1001, 9, 0, 0, 10, 1'b1);
      tick();
      check_eq("wrap_first", int'(bus.out_id), 3);
      tick();
      check_eq("wrap_second", int'(bus.out_id), 0);

      // Reset while holding a stalled result.
      drive(4'b1111, 11, 12, 13, 14, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive('0, 0, 0, 0, 0, 1'b1);
      check_eq("rst_mid_valid", int'(bus.out_valid), 0);
      check_eq("rst_mid_data", int'(bus.out_data), 0);
      check_eq("rst_mid_cnt", int'(bus.op_cnt), 0);
      tick();

      // Random traffic with occasional resets and backpressure.
      for (int n = 0; n < 1500; n++) begin
         drive(4'($urandom_range(0, 15)), $urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 3) != 0));
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      drive('0, 0, 0, 0, 0, 1'b1);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
